// File: rtl/servo_pkg.sv
// Types and default timing constants shared by the servo PWM decoder and generator.
// Defaults assume a 100 MHz clock.
package servo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int DEF_MIN_WIDTH = 50000;
    localparam int DEF_MAX_WIDTH = 250000;
    localparam int DEF_TIMEOUT   = 4000000;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus a delay flop, producing the synchronized level
// and single-cycle rise/fall pulses.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic       s1;
    logic       s2;
    logic       s_d;
    logic [2:0] primed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s_d    <= 1'b0;
            primed <= 3'b000;
        end else begin
            s1     <= din;
            s2     <= s1;
            s_d    <= s2;
            primed <= {primed[1:0], 1'b1};
        end
    end

    // A rise is only believed once s_d holds a real sample, so a line that is
    // already high when reset releases does not look like a fresh edge.
    assign level = s2;
    assign rise  = s2 & ~s_d & primed[2];
    assign fall  = ~s2 & s_d;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Measures servo PWM high time and rise-to-rise period in clock cycles,
// flags out-of-range widths and declares loss of signal.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int MIN_WIDTH = DEF_MIN_WIDTH,
    parameter int MAX_WIDTH = DEF_MAX_WIDTH,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] pulse_width,
    output logic [CNT_W-1:0] period,
    output logic             width_valid,
    output logic             period_valid,
    output logic             range_err,
    output logic             timeout,
    output state_t           fsm_state
);

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_WIDTH);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WIDTH);
    localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);

    state_t           state;
    state_t           state_nxt;
    logic             lost;
    logic             s;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] per_cnt;

    sync_edge_detect u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pwm_in),
        .level (s),
        .rise  (rise),
        .fall  (fall)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= TO_C) ? TO_C : v + CNT_W'(1);
    endfunction

    // Edges take priority over the timeout check in the same cycle.
    always_comb begin
        state_nxt = state;
        lost      = 1'b0;
        case (state)
            IDLE: if (rise) state_nxt = HIGH;
            HIGH: begin
                if (fall) begin
                    state_nxt = LOW;
                end else if (hi_cnt >= TO_C || per_cnt >= TO_C) begin
                    state_nxt = IDLE;
                    lost      = 1'b1;
                end
            end
            LOW: begin
                if (rise) begin
                    state_nxt = HIGH;
                end else if (per_cnt >= TO_C) begin
                    state_nxt = IDLE;
                    lost      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hi_cnt       <= '0;
            per_cnt      <= '0;
            pulse_width  <= '0;
            period       <= '0;
            width_valid  <= 1'b0;
            period_valid <= 1'b0;
            range_err    <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_nxt;
            width_valid  <= 1'b0;
            period_valid <= 1'b0;
            range_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        hi_cnt  <= CNT_W'(1);
                        per_cnt <= CNT_W'(1);
                        timeout <= 1'b0;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        pulse_width <= hi_cnt;
                        width_valid <= 1'b1;
                        range_err   <= (hi_cnt < MIN_C) || (hi_cnt > MAX_C);
                        per_cnt     <= sat_inc(per_cnt);
                    end else if (lost) begin
                        timeout <= 1'b1;
                    end else begin
                        hi_cnt  <= sat_inc(hi_cnt);
                        per_cnt <= sat_inc(per_cnt);
                    end
                end
                LOW: begin
                    if (rise) begin
                        period       <= per_cnt;
                        period_valid <= 1'b1;
                        hi_cnt       <= CNT_W'(1);
                        per_cnt      <= CNT_W'(1);
                    end else if (lost) begin
                        timeout <= 1'b1;
                    end else begin
                        per_cnt <= sat_inc(per_cnt);
                    end
                end
                default: ;
            endcase
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Bench for servo_pwm_decoder with timing parameters scaled down by 1000.
module tb_servo_pwm_decoder;
    import servo_pkg::*;

    localparam int W       = 16;
    localparam int MIN_W   = 50;
    localparam int MAX_W   = 250;
    localparam int TO      = 4000;

    logic         clk;
    logic         rst_n;
    logic         pwm_in;
    logic [W-1:0] pulse_width;
    logic [W-1:0] period;
    logic         width_valid;
    logic         period_valid;
    logic         range_err;
    logic         timeout;
    state_t       fsm_state;

    servo_pwm_decoder #(
        .CNT_W     (W),
        .MIN_WIDTH (MIN_W),
        .MAX_WIDTH (MAX_W),
        .TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwm_in       (pwm_in),
        .pulse_width  (pulse_width),
        .period       (period),
        .width_valid  (width_valid),
        .period_valid (period_valid),
        .range_err    (range_err),
        .timeout      (timeout),
        .fsm_state    (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // scoreboard: {range_err, width} and period expectations
    logic [W:0]   exp_w_q[$];
    logic [W-1:0] exp_p_q[$];

    bit           train    = 1'b0;
    int           prev_len = 0;
    logic [W-1:0] last_w   = '0;
    logic [W-1:0] last_p   = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (cyc > 60000) begin
            $display("FAIL watchdog: got %0d cycles expected at most 60000", cyc);
            $fatal(1, "watchdog expired");
        end
    end

    // monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (width_valid) begin
                if (exp_w_q.size() == 0) begin
                    check("w_extra", width_valid, 0);
                end else begin
                    logic [W:0] e;
                    e = exp_w_q.pop_front();
                    check("width", pulse_width, e[W-1:0]);
                    check("range_err", range_err, e[W]);
                end
            end else if (range_err) begin
                check("rerr_lone", range_err, 0);
            end
            if (period_valid) begin
                if (exp_p_q.size() == 0) begin
                    check("p_extra", period_valid, 0);
                end else begin
                    logic [W-1:0] e;
                    e = exp_p_q.pop_front();
                    check("period", period, e);
                end
            end
        end
    end

    // driver: rise pushes the previous period (if in a train) and this width
    task automatic note_rise(input int hi);
        if (train) begin
            exp_p_q.push_back(W'(prev_len));
            last_p = W'(prev_len);
        end
        if (hi > 0) begin
            exp_w_q.push_back({(hi < MIN_W) || (hi > MAX_W), W'(hi)});
            last_w = W'(hi);
        end
        train = 1'b1;
    endtask

    task automatic pulse(input int hi, input int lo);
        note_rise(hi);
        prev_len = hi + lo;
        pwm_in = 1'b1;
        repeat (hi) @(negedge clk);
        pwm_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pw"}, pulse_width, 0);
        check({tag, "_per"}, period, 0);
        check({tag, "_wv"}, width_valid, 0);
        check({tag, "_pv"}, period_valid, 0);
        check({tag, "_re"}, range_err, 0);
        check({tag, "_to"}, timeout, 0);
        check({tag, "_st"}, fsm_state, IDLE);
    endtask

    initial begin
        int waited;
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_outputs("post_rst");

        // nominal 1.5 ms / 20 ms train
        for (int i = 0; i < 3; i++) pulse(150, 1850);

        // out of range, then exact limits, then a one-cycle glitch
        pulse(40, 500);
        pulse(300, 500);
        pulse(MIN_W, 500);
        pulse(MAX_W, 500);
        pulse(1, 300);
        pulse(100, 500);

        // loss of signal
        pulse(150, 0);
        waited = 0;
        while (!timeout && waited < TO + 500) begin
            @(negedge clk);
            waited++;
        end
        check("timeout_set", timeout, 1);
        check("to_pw_held", pulse_width, last_w);
        check("to_per_held", period, last_p);
        check("to_state", fsm_state, IDLE);
        train = 1'b0;
        repeat (20) @(negedge clk);
        pulse(120, 600);
        check("timeout_clr", timeout, 0);
        pulse(130, 600);

        // reset in the middle of a high pulse, released while still high
        note_rise(0);
        pwm_in = 1'b1;
        repeat (70) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        train  = 1'b0;
        last_w = '0;
        last_p = '0;
        repeat (77) @(negedge clk);
        pwm_in = 1'b0;
        repeat (500) @(negedge clk);
        check("mid_rst_pw", pulse_width, 0);
        pulse(150, 600);
        pulse(150, 600);

        repeat (20) @(negedge clk);
        check("w_q_drained", exp_w_q.size(), 0);
        check("p_q_drained", exp_p_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
